da_lut_writer: RTL and testbench

Generates the distributed-arithmetic partial-sum lookup table for the FIR and writes it, one entry per clock, into the LUT memory that the FIR datapath later reads. Accepts TAPS coefficients over a valid/ready stream, then sweeps all 2^TAPS addresses in Gray-code order. Each entry is the sum of the coefficients selected by the address bits. Each new sum is formed incrementally, by one add or subtract per cycle.

---
 rtl/da_lut_writer.sv | 193 +++++++++++++++++++
 tb/tb_da_lut_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/da_lut_writer.sv
// rtl/da_lut_writer.sv - distributed-arithmetic partial-sum LUT generator
//
// Purpose:
//   Loads TAPS signed coefficients over a valid/ready stream, then writes
//   the 2^TAPS-entry DA partial-sum table, one entry per clock. Addresses
//   are swept in Gray-code order so each entry differs from the previous
//   one by a single coefficient: one add or subtract per cycle.
//   LUT[a] = sum of coef[k] for every bit k set in a.
//
// Optional feature (macro DA_LUT_NEG_EN):
//   A second pass follows the first, with address bit TAPS set and the
//   negated sums written. This fills the sign-bit half of the table.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_start        begin a load (honoured only in IDLE)
//   i_coef_valid   coefficient present on i_coef
//   i_coef         signed coefficient
//   o_coef_ready   coefficient accepted this cycle (LOAD only)
//   o_we           LUT write strobe
//   o_waddr        LUT write address, zero-extended
//   o_wdata        LUT write data, sign-extended partial sum
//   o_busy         high during LOAD and GEN
//   o_done         one-cycle pulse after the last write
module da_lut_writer #(
  parameter int TAPS      = 4,
  parameter int COEF_W    = 8,
  parameter int OPSIZE    = 12,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_coef_valid,
  input  logic [COEF_W-1:0]    i_coef,
  output logic                 o_coef_ready,
  output logic                 o_we,
  output logic [ADDR_SIZE-1:0] o_waddr,
  output logic [OPSIZE-1:0]    o_wdata,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
`ifdef DA_LUT_NEG_EN
  localparam int AW_NEED = TAPS + 1;
`else
  localparam int AW_NEED = TAPS;
`endif

  generate
    if (OPSIZE < COEF_W + $clog2(TAPS)) begin : g_bad_opsize
      $error("da_lut_writer: OPSIZE too small to hold the sum of TAPS coefficients");
    end
    if (ADDR_SIZE < AW_NEED) begin : g_bad_addr
      $error("da_lut_writer: ADDR_SIZE too small for the LUT address range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [TAPS-1:0]     m_q;       // step index within the current pass
  logic [OPSIZE-1:0]   s_q;       // running partial sum S(n)
  logic [COEF_W-1:0]   coef_q [TAPS];
  logic                coef_ready_q, we_q, busy_q, done_q;
  logic [ADDR_SIZE-1:0] waddr_q;
  logic [OPSIZE-1:0]   wdata_q;

  // Next-step values for the Gray sweep.
  logic [TAPS-1:0]     m_d;
  logic [TAPS-1:0]     g_d;
  logic [KW-1:0]       b;
  logic [OPSIZE-1:0]   coef_ext;
  logic [OPSIZE-1:0]   s_d;
  logic                m_last;
  logic                gen_end;
  logic [ADDR_SIZE-1:0] waddr_d;
  logic [OPSIZE-1:0]   wdata_d;

`ifdef DA_LUT_NEG_EN
  logic pass_q;
  logic pass_d;
`endif

  always_comb begin
    m_d = m_q + 1'b1;
    g_d = m_d ^ (m_d >> 1);
    // The flipping Gray bit is the lowest set bit of n+1. On wrap to 0
    // (end of a pass) the MSB flips back, which returns S to zero.
    b = KW'(TAPS - 1);
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (m_d[i]) b = KW'(i);
    end
    coef_ext = OPSIZE'($signed(coef_q[b]));
    s_d      = g_d[b] ? (s_q + coef_ext) : (s_q - coef_ext);
    m_last   = &m_q;
`ifdef DA_LUT_NEG_EN
    pass_d   = pass_q | m_last;
    gen_end  = m_last & pass_q;
    waddr_d  = ADDR_SIZE'({pass_d, g_d});
    wdata_d  = pass_d ? (OPSIZE'(0) - s_d) : s_d;
`else
    gen_end  = m_last;
    waddr_d  = ADDR_SIZE'(g_d);
    wdata_d  = s_d;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      m_q          <= '0;
      s_q          <= '0;
      coef_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
`ifdef DA_LUT_NEG_EN
      pass_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            state_q      <= LOAD;
            k_q          <= '0;
            busy_q       <= 1'b1;
            coef_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (i_coef_valid) begin
            coef_q[k_q] <= i_coef;
            k_q         <= k_q + 1'b1;
            if (k_q == KW'(TAPS - 1)) begin
              // Write 0 (address 0, sum 0) is presented straight away.
              state_q      <= GEN;
              coef_ready_q <= 1'b0;
              m_q          <= '0;
              s_q          <= '0;
              we_q         <= 1'b1;
              waddr_q      <= '0;
              wdata_q      <= '0;
`ifdef DA_LUT_NEG_EN
              pass_q       <= 1'b0;
`endif
            end
          end
        end
        GEN: begin
          if (gen_end) begin
            state_q <= DONE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
          end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            we_q    <= 1'b1;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef DA_LUT_NEG_EN
            pass_q  <= pass_d;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_coef_ready = coef_ready_q;
  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_da_lut_writer.sv
// tb/tb_da_lut_writer.sv - self-checking bench for da_lut_writer
module tb_da_lut_writer;

  localparam int TAPS      = 4;
  localparam int COEF_W    = 8;
  localparam int OPSIZE    = 12;
  localparam int ADDR_SIZE = 8;
`ifdef DA_LUT_NEG_EN
  localparam int NW = 2 << TAPS;
`else
  localparam int NW = 1 << TAPS;
`endif

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_start;
  logic                 i_coef_valid;
  logic [COEF_W-1:0]    i_coef;
  logic                 o_coef_ready;
  logic                 o_we;
  logic [ADDR_SIZE-1:0] o_waddr;
  logic [OPSIZE-1:0]    o_wdata;
  logic                 o_busy;
  logic                 o_done;

  da_lut_writer #(
    .TAPS(TAPS), .COEF_W(COEF_W), .OPSIZE(OPSIZE), .ADDR_SIZE(ADDR_SIZE)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_coef_valid(i_coef_valid), .i_coef(i_coef), .o_coef_ready(o_coef_ready),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  logic signed [COEF_W-1:0] mc [TAPS];
  logic [OPSIZE-1:0]        lut_seen [0:31];

  typedef struct {
    logic [31:0]       cpack;
    int                addr;
    logic [OPSIZE-1:0] exp;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference table entry: sum of selected coefficients, negated in the
  // sign-bit half, truncated to the LUT word width.
  function automatic logic [OPSIZE-1:0] lut_model(input int a);
    int s;
    s = 0;
    for (int k = 0; k < TAPS; k++) if (a[k]) s += int'(mc[k]);
    if (a[TAPS]) s = -s;
    return s[OPSIZE-1:0];
  endfunction

  // Address of write number w: pass number on bit TAPS, Gray code below.
  function automatic int exp_addr(input int w);
    int m;
    m = w % (1 << TAPS);
    return ((w / (1 << TAPS)) << TAPS) | (m ^ (m >> 1));
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(o_we), 32'd0);
    chk({tag, "_waddr"}, 32'(o_waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(o_wdata), 32'd0);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_done), 32'd0);
    chk({tag, "_ready"}, 32'(o_coef_ready), 32'd0);
  endtask

  // One full load + generate. seq gives the i_coef_valid pattern (LSB
  // first); abort_at >= 0 asserts reset while that write is on the bus.
  task automatic run_gen(input logic [31:0] cpack, input logic [31:0] seq,
                         input int seq_len, input bit start_in_gen, input int abort_at);
    int ci, writes, done_cnt, first_we, last_we, done_cyc;
    bit aborted;
    ci = 0; writes = 0; done_cnt = 0; first_we = 0; last_we = 0; done_cyc = 0;
    aborted = 1'b0;
    for (int k = 0; k < TAPS; k++) mc[k] = cpack[8*k +: 8];
    for (int a = 0; a < 32; a++) lut_seen[a] = 'x;

    @(negedge i_clk);
    chk("idle_ready", 32'(o_coef_ready), 32'd0);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_ready", 32'(o_coef_ready), 32'd1);

    for (int s = 0; s < seq_len && ci < TAPS; s++) begin
      i_coef_valid = seq[s];
      i_coef = seq[s] ? mc[ci] : COEF_W'($urandom);
      @(negedge i_clk);
      if (seq[s]) ci++;
      if (ci < TAPS) begin
        chk("load_stall_we", 32'(o_we), 32'd0);
        chk("load_stall_ready", 32'(o_coef_ready), 32'd1);
      end
    end
    i_coef_valid = 1'b0;
    chk("load_count", 32'(ci), 32'(TAPS));

    for (int cyc = 1; cyc <= NW + 8; cyc++) begin
      if (o_we) begin
        if (first_we == 0) first_we = cyc;
        last_we = cyc;
        chk("waddr", 32'(o_waddr), 32'(exp_addr(writes)));
        chk("wdata", 32'(o_wdata), 32'(lut_model(exp_addr(writes))));
        lut_seen[o_waddr[4:0]] = o_wdata;
        writes++;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy", 32'(o_busy), 32'd0);
      end
      i_start = start_in_gen && (writes == 3);
      if (abort_at >= 0 && writes == abort_at + 1) begin
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk_reset_outputs("abort");
        i_rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;

    if (!aborted) begin
      chk("write_count", 32'(writes), 32'(NW));
      chk("first_we_cyc", 32'(first_we), 32'd1);
      chk("last_we_cyc", 32'(last_we), 32'(NW));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cyc", 32'(done_cyc), 32'(NW + 1));
      chk("idle_after_busy", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] loaded;
    logic [31:0] seq;
    int          len;

    i_rst_n = 1'b0; i_start = 1'b0; i_coef_valid = 1'b0; i_coef = '0;
    repeat (3) @(negedge i_clk);
    chk_reset_outputs("reset");
    i_rst_n = 1'b1;

    vecs.push_back('{32'h08040201, 'h0, 12'h000});
    vecs.push_back('{32'h08040201, 'h5, 12'h005});
    vecs.push_back('{32'h08040201, 'hF, 12'h00F});
    vecs.push_back('{32'hFF0705FD, 'h1, 12'hFFD});
    vecs.push_back('{32'hFF0705FD, 'h6, 12'h00C});
    vecs.push_back('{32'hFF0705FD, 'h9, 12'hFFC});
    vecs.push_back('{32'hFF0705FD, 'hF, 12'h008});
    vecs.push_back('{32'hFF0705FD, 'h0, 12'h000});
`ifdef DA_LUT_NEG_EN
    vecs.push_back('{32'h08040201, 'h1F, 12'hFF1});
    vecs.push_back('{32'h08040201, 'h10, 12'h000});
`endif

    loaded = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].cpack != loaded) begin
        run_gen(vecs[i].cpack, 32'hF, 4, 1'b0, -1);
        loaded = vecs[i].cpack;
      end
      chk($sformatf("lut_vec%0d", i), 32'(lut_seen[vecs[i].addr]), 32'(vecs[i].exp));
    end

    // valid pattern 1,0,0,1,1,0,1
    run_gen(32'h281E140A, 32'd89, 7, 1'b0, -1);
    chk("toggle_c0", 32'(lut_seen[1]), 32'h00A);
    chk("toggle_c3", 32'(lut_seen[8]), 32'h028);

    run_gen(32'h08040201, 32'hF, 4, 1'b1, -1);

    run_gen(32'h08040201, 32'hF, 4, 1'b0, 5);
    run_gen(32'h08040201, 32'hF, 4, 1'b0, -1);
    chk("post_abort_lutF", 32'(lut_seen[15]), 32'h00F);

    for (int r = 0; r < 6; r++) begin
      seq = '0; len = 0;
      for (int k = 0; k < TAPS; k++) begin
        len += $urandom_range(0, 2);
        seq[len] = 1'b1;
        len++;
      end
      @(negedge i_clk);
      i_coef_valid = 1'b1;
      i_coef = COEF_W'($urandom);
      @(negedge i_clk);
      i_coef_valid = 1'b0;
      run_gen($urandom, seq, len, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
